// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - ALU_* : 4-bit alu_ctrl operation codes (1010-1111 are undefined)
//   - ALU_OP_* : 2-bit alu_op encodings fed to the ALU decoder
//   - state_e : execute-unit FSM states
//   - is_shift_op() : true for the serially executed shift codes
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: 1-bit-per-cycle shifter for the execute unit.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : drop any shift in progress (counter to 0)
//   load         : start a shift; load_val/load_left/load_arith/load_cnt
//   first_step   : load_val shifted by one (combinational)
//   shift_out    : working register shifted by one (combinational)
//   done         : final step happens at the coming edge
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [XLEN-1:0]    load_val,
  input  logic [SHAMT_W-1:0] load_cnt,
  input  logic               load_left,
  input  logic               load_arith,
  output logic [XLEN-1:0]    first_step,
  output logic [XLEN-1:0]    shift_out,
  output logic               done
);

  logic [XLEN-1:0]    work_q,  work_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic               left_q,  left_d;
  logic               arith_q, arith_d;

  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v,
                                             input logic left,
                                             input logic arith);
    if (left) return {v[XLEN-2:0], 1'b0};
    return {arith & v[XLEN-1], v[XLEN-1:1]};
  endfunction

  assign first_step = shift1(load_val, load_left, load_arith);
  assign shift_out  = shift1(work_q, left_q, arith_q);
  assign done       = (cnt_q == SHAMT_W'(1));

  // The first bit is shifted on the load edge, so load_cnt is the number
  // of steps still to go (total amount minus one).
  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      work_d  = first_step;
      cnt_d   = load_cnt;
      left_d  = load_left;
      arith_d = load_arith;
    end else if (cnt_q != '0) begin
      work_d = shift_out;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered, handshaked output.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop in-flight work and the pending result
//   in_valid/in_ready   : upstream handshake for alu_ctrl/op_a/op_b/rd_in
//   out_valid/out_ready : downstream handshake for result/zero/rd_out/illegal
// Single-cycle ops (and shifts by 0 or 1) produce their result one cycle
// after accept; shifts by s>1 use the serial shifter and take s cycles.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RD_W-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [RD_W-1:0] rd_out,
  output logic            illegal
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  state_e          state_q,     state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q,    result_d;
  logic            zero_q,      zero_d;
  logic [RD_W-1:0] rd_out_q,    rd_out_d;
  logic            illegal_q,   illegal_d;
  logic [RD_W-1:0] rd_shift_q,  rd_shift_d;

  logic [SHAMT_W-1:0] shamt;
  logic               multi_cycle;
  logic               accept;
  logic [XLEN-1:0]    alu_res;
  logic               alu_illegal;
  logic [XLEN-1:0]    sh_first;
  logic [XLEN-1:0]    sh_out;
  logic               sh_done;

  assign shamt       = op_b[SHAMT_W-1:0];
  assign multi_cycle = is_shift_op(alu_ctrl) && (shamt > SHAMT_W'(1));
  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept      = in_valid && in_ready;

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .load       (accept && multi_cycle),
    .load_val   (op_a),
    .load_cnt   (shamt - SHAMT_W'(1)),
    .load_left  (alu_ctrl == ALU_SLL),
    .load_arith (alu_ctrl == ALU_SRA),
    .first_step (sh_first),
    .shift_out  (sh_out),
    .done       (sh_done)
  );

  // Shifts by 0 or 1 finish here; longer ones go through SHIFT.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_SLL, ALU_SRL, ALU_SRA:
                alu_res = (shamt == '0) ? op_a : sh_first;
      default:  alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    rd_out_d    = rd_out_q;
    illegal_d   = illegal_q;
    rd_shift_d  = rd_shift_q;
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else if (state_q == SHIFT) begin
      if (sh_done) begin
        out_valid_d = 1'b1;
        result_d    = sh_out;
        zero_d      = (sh_out == '0);
        rd_out_d    = rd_shift_q;
        illegal_d   = 1'b0;
        state_d     = IDLE;
      end
    end else if (accept) begin
      if (multi_cycle) begin
        rd_shift_d = rd_in;
        state_d    = SHIFT;
      end else begin
        out_valid_d = 1'b1;
        result_d    = alu_res;
        zero_d      = (alu_res == '0);
        rd_out_d    = rd_in;
        illegal_d   = alu_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      rd_out_q    <= '0;
      illegal_q   <= 1'b0;
      rd_shift_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      rd_out_q    <= rd_out_d;
      illegal_q   <= illegal_d;
      rd_shift_q  <= rd_shift_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign rd_out    = rd_out_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit. The driver pushes
// expected responses (from a plain-arithmetic reference model) at accept;
// the monitor pops and compares whenever a result is presented.
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [RD_W-1:0] rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [RD_W-1:0] rd_out;
  logic            illegal;

  alu_exec_unit #(
    .XLEN (XLEN),
    .RD_W (RD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .rd_out    (rd_out),
    .illegal   (illegal)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    logic            zero;
    logic [RD_W-1:0] rd;
    logic            ill;
    int              vis;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   head_seen = 0;
  int   acc_cyc = -1;
  int   busy_until = -1;
  bit   rand_ready = 0;
  bit   ready_val = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the ISA meaning of each code.
  function automatic logic [XLEN-1:0] model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    int unsigned s;
    s = b % XLEN;
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << s;
      4'd3:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd4:    return (a < b) ? 1 : 0;
      4'd5:    return a ^ b;
      4'd6:    return a >> s;
      4'd7:    return $signed(a) >>> s;
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 0;
    endcase
  endfunction

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_pending();
    sbq.delete();
    head_seen  = 0;
    busy_until = -1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept cycle.
  task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RD_W-1:0] rd, output int acc);
    exp_t        e;
    int unsigned s;
    int          lat;
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    rd_in    = rd;
    acc      = -1;
    for (int t = 0; t < 200 && acc < 0; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc    = cyc;
        s      = b % XLEN;
        lat    = ((c == 4'd2 || c == 4'd6 || c == 4'd7) && s != 0) ? int'(s) : 1;
        e.res  = model(c, a, b);
        e.zero = (e.res == 0);
        e.rd   = rd;
        e.ill  = (c > 4'd9);
        e.vis  = cyc + lat;
        sbq.push_back(e);
        acc_cyc    = cyc;
        busy_until = cyc + lat - 1;
      end
      next_slot();
    end
    in_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    next_slot();
    flush = 1'b0;
    drop_pending();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_zero"}, zero, 1);
    chk({tag, "_rd_out"}, rd_out, 0);
    chk({tag, "_illegal"}, illegal, 0);
  endtask

  // Monitor / scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (cyc > acc_cyc && cyc <= busy_until) chk("busy_in_ready", in_ready, 0);
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          e = sbq[0];
          if (!head_seen) begin
            chk("latency", cyc, e.vis);
            head_seen = 1;
          end
          chk("result", result, e.res);
          chk("zero", zero, e.zero);
          chk("rd_out", rd_out, e.rd);
          chk("illegal", illegal, e.ill);
          if (out_ready) begin
            void'(sbq.pop_front());
            head_seen = 0;
          end
        end
      end else if (sbq.size() != 0) begin
        if (head_seen) begin
          chk("valid_dropped", out_valid, 1);
          head_seen = 0;
        end else if (cyc > sbq[0].vis) begin
          chk("late_result", cyc, sbq[0].vis);
          head_seen = 1;
        end
      end
    end
  end

  initial begin
    int              a1, a2, a3, acc;
    logic [3:0]      c;
    logic [XLEN-1:0] ra, rb;
    int unsigned     k;

    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    alu_ctrl = '0;
    op_a     = '0;
    op_b     = '0;
    rd_in    = '0;
    repeat (3) next_slot();
    @(negedge clk);
    chk_reset("reset");
    next_slot();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    next_slot();

    // Directed single-cycle ops, back-to-back
    issue(4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd3, a1);
    issue(4'b0001, 32'd5, 32'd5, 5'd4, a1);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd5, a2);
    issue(4'b0100, 32'hFFFF_FFFF, 32'd1, 5'd6, a3);
    chk("b2b_slt_after_sub", a2 - a1, 1);
    chk("b2b_sltu_after_slt", a3 - a2, 1);

    // Shifts
    issue(4'b0111, 32'h8000_0010, 32'd4, 5'd7, acc);
    issue(4'b0110, 32'h8000_0010, 32'd4, 5'd8, acc);
    issue(4'b0010, 32'h1234_5678, 32'd0, 5'd9, acc);
    issue(4'b0110, 32'hF000_0000, 32'h25, 5'd10, acc);
    issue(4'b0111, 32'h8000_0001, 32'd1, 5'd11, acc);
    issue(4'b0111, 32'h8000_0000, 32'd31, 5'd12, acc);

    // Illegal code
    issue(4'b1100, 32'hDEAD_BEEF, 32'h1, 5'd13, acc);

    // Backpressure: result held for 3 cycles, next op accepted on handshake
    repeat (3) next_slot();
    ready_val = 1'b0;
    next_slot();
    issue(4'b0101, 32'hA5A5_0000, 32'h0000_5A5A, 5'd14, a1);
    fork
      issue(4'b1000, 32'h0F00_0000, 32'h0000_00F0, 5'd15, a2);
      begin
        repeat (3) @(posedge clk);
        ready_val = 1'b1;
      end
    join
    chk("bp_accept_cycle", a2, a1 + 4);
    repeat (2) next_slot();

    // Flush mid-shift: sll s=20 accepted at N, flush during N+5
    issue(4'b0010, 32'h0000_0001, 32'd20, 5'd16, acc);
    repeat (4) next_slot();
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'b0000;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    next_slot();
    flush    = 1'b0;
    in_valid = 1'b0;
    drop_pending();
    @(negedge clk);
    chk("post_flush_cycle", cyc, acc + 6);
    chk("post_flush_in_ready", in_ready, 1);
    chk("post_flush_out_valid", out_valid, 0);
    repeat (25) next_slot();

    // Reset mid-shift
    issue(4'b0010, 32'h0000_0003, 32'd20, 5'd17, acc);
    repeat (3) next_slot();
    rst = 1'b1;
    next_slot();
    @(negedge clk);
    chk_reset("mid_shift_reset");
    next_slot();
    rst = 1'b0;
    drop_pending();
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    next_slot();

    // Randomized traffic with random backpressure and occasional flush
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 11);
      c  = (k >= 10) ? 4'($urandom_range(10, 15)) : 4'(k);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h3;
      if ($urandom_range(0, 7) == 0) rb = ra;
      issue(c, ra, rb, 5'($urandom), acc);
      if ($urandom_range(0, 24) == 0) flush_pulse();
      else if ($urandom_range(0, 3) == 0) next_slot();
    end

    // Drain
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    for (int t = 0; t < 200 && sbq.size() != 0; t++) next_slot();
    chk("drain_empty", sbq.size(), 0);
    repeat (3) next_slot();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
